dmem_port_arbiter: RTL

// - Shares the single 16x8 data memory between the CPU load/store port and a host/debug port.
// - The host port is used for preload and inspection while the CPU runs.
// - CPU has priority. The host is guaranteed service after STARVE_LIMIT waiting cycles.
// - Host may lock the memory for multi-cycle sequences. The CPU is stalled (PC/regfile write

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/arb_sat_counter.sv | 37 +++
 rtl/dmem_port_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM state, port ownership
// and the statistics counter width.
package dmem_arb_pkg;

  typedef enum logic {
    ARB         = 1'b0,
    HOST_LOCKED = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment)
// and asynchronous active-high reset.
module arb_sat_counter #(
  parameter int          WIDTH = 4,
  parameter int unsigned MAX   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX_V)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data memory between the CPU port (priority) and a
// host/debug port with starvation guarantee and bounded locking.
// Optional statistics outputs are built when DMEM_ARB_STATS_EN is defined.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 3,
  parameter int LOCK_MAX     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output arb_state_t        dbg_state
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_stall_cnt,
  output logic [STAT_W-1:0] stat_host_cnt
`endif
);

  localparam int STARVE_W = 4;
  localparam int LOCK_W   = 8;

  arb_state_t          state_q, state_d;
  owner_t              owner;
  logic                grant_host, grant_cpu;
  logic [STARVE_W-1:0] starve_cnt;
  logic [LOCK_W-1:0]   lock_cnt;
  logic                host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;

  // starve_cnt tracks consecutive denied host cycles; any grant or a dropped
  // request restarts the count.
  arb_sat_counter #(.WIDTH(STARVE_W), .MAX(STARVE_LIMIT)) u_starve_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (host_req & ~grant_host),
    .clr   (grant_host | ~host_req),
    .count (starve_cnt)
  );

  // lock_cnt is held at zero in ARB so every lock episode starts fresh.
  arb_sat_counter #(.WIDTH(LOCK_W), .MAX(LOCK_MAX - 1)) u_lock_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (state_q == HOST_LOCKED),
    .clr   (state_q == ARB),
    .count (lock_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB: begin
        if (grant_host && host_lock) state_d = HOST_LOCKED;
      end
      HOST_LOCKED: begin
        if ((grant_host && !host_lock) || !host_req ||
            (lock_cnt == LOCK_W'(LOCK_MAX - 1))) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Grants are gated by reset so nothing reaches the memory while reset is held.
  always_comb begin
    grant_host = 1'b0;
    grant_cpu  = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ARB: begin
          grant_host = host_req & (~cpu_req | (starve_cnt == STARVE_W'(STARVE_LIMIT)));
          grant_cpu  = cpu_req & ~grant_host;
        end
        HOST_LOCKED: grant_host = host_req;
        default: ;
      endcase
    end

    owner = OWN_NONE;
    if (grant_host) owner = OWN_HOST;
    else if (grant_cpu) owner = OWN_CPU;

    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (owner)
      OWN_HOST: begin
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
      end
      OWN_CPU: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      default: ;
    endcase

    cpu_stall  = ~reset & cpu_req & ~grant_cpu;
    host_ready = grant_host;
  end

  always_comb begin
    host_rvalid_d = grant_host & ~host_we;
    host_rdata_d  = host_rvalid_d ? mem_rdata : host_rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign cpu_rdata   = mem_rdata;
  assign dbg_state   = state_q;

`ifdef DMEM_ARB_STATS_EN
  arb_sat_counter #(.WIDTH(STAT_W), .MAX(16'hFFFF)) u_stat_stall (
    .clk   (clk),
    .rst   (reset),
    .inc   (cpu_stall),
    .clr   (1'b0),
    .count (stat_stall_cnt)
  );

  arb_sat_counter #(.WIDTH(STAT_W), .MAX(16'hFFFF)) u_stat_host (
    .clk   (clk),
    .rst   (reset),
    .inc   (grant_host),
    .clr   (1'b0),
    .count (stat_host_cnt)
  );
`endif

endmodule
